// File: rtl/frame_buffer_ctrl_pkg.sv
// Shared definitions for the frame buffer write-side controller:
// command opcodes, controller FSM states and the frame buffer geometry.
package frame_buffer_ctrl_pkg;

    // Number of 1-bit pixels in the frame buffer (128 rows x 256 columns).
    localparam int FB_DEPTH = 32768;

    // Command opcodes carried on CMD_OP.
    typedef enum logic [1:0] {
        OP_FILL_SOLID  = 2'b00,
        OP_FILL_CHECK  = 2'b01,
        OP_SET_COLOURS = 2'b10,
        OP_RESERVED    = 2'b11
    } cmd_op_e;

    // Controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FILL    = 2'b01,
        ST_WAIT_VS = 2'b10
    } fsm_state_e;

    // Checkerboard pixel: alternates along a row (col LSB) and flips every
    // row (row LSB sits at address bit 8 in the {row, col} layout).
    function automatic logic checker_pixel(input logic row_lsb, input logic col_lsb);
        return row_lsb ^ col_lsb;
    endfunction

endpackage

// File: rtl/frame_buffer_ctrl_fb_write_arbiter.sv
// Two-requester arbiter for the frame buffer write port. In fill mode a
// contested cycle goes to whichever requester lost the previous contest;
// outside fill mode the bus owns the port outright.
module fb_write_arbiter (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_fill_mode,
    input  logic i_bus_req,
    input  logic i_fill_req,
    output logic o_bus_gnt,
    output logic o_fill_gnt
);

    // 1 = the fill engine won the last contested cycle, 0 = the bus did.
    logic r_last_fill;
    logic w_contest;

    assign w_contest = i_fill_mode & i_bus_req & i_fill_req;

    // Grant decision: alternate on contention, otherwise grant the sole requester.
    always_comb begin
        o_bus_gnt  = 1'b0;
        o_fill_gnt = 1'b0;
        if (!i_fill_mode) begin
            o_bus_gnt = i_bus_req;
        end else if (w_contest) begin
            o_bus_gnt  = r_last_fill;
            o_fill_gnt = ~r_last_fill;
        end else begin
            o_bus_gnt  = i_bus_req;
            o_fill_gnt = i_fill_req;
        end
    end

    // Remember the winner of each contested cycle; resets as "bus won".
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last_fill <= 1'b0;
        end else if (w_contest) begin
            r_last_fill <= o_fill_gnt;
        end
    end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Write-side controller for the 1-bit VGA frame buffer. Shares the single
// write port between the bus and an internal whole-screen fill engine,
// and owns the colour register, which only changes at a vsync falling edge.
module frame_buffer_ctrl
    import frame_buffer_ctrl_pkg::*;
#(
    parameter int          ADDR_WIDTH   = $clog2(FB_DEPTH),
    parameter logic [15:0] COLOUR_RESET = 16'h00FF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  BUS_VALID,
    input  logic [ADDR_WIDTH-1:0] BUS_ADDR,
    input  logic                  BUS_DATA,
    output logic                  BUS_READY,
    input  logic                  CMD_VALID,
    input  logic [1:0]            CMD_OP,
    input  logic [15:0]           CMD_DATA,
    output logic                  CMD_READY,
    input  logic                  VGA_VS,
    output logic                  FB_WE,
    output logic [ADDR_WIDTH-1:0] FB_ADDR,
    output logic                  FB_DATA,
    output logic [15:0]           CONFIG_COLOURS,
    output logic                  BUSY
);

    // Last address of a fill pass; the fill stops here rather than wrapping.
    localparam logic [ADDR_WIDTH-1:0] FILL_LAST = '1;

    fsm_state_e            r_state;
    fsm_state_e            w_next_state;
    cmd_op_e               w_op;

    logic [ADDR_WIDTH-1:0] r_fill_addr;
    logic                  r_pattern_check;
    logic                  r_solid_val;

    logic [15:0]           r_pending_colour;
    logic [15:0]           r_colours;
    logic                  r_vs_d;

    logic                  r_fb_we;
    logic [ADDR_WIDTH-1:0] r_fb_addr;
    logic                  r_fb_data;

    logic                  w_cmd_accept;
    logic                  w_fill_cmd;
    logic                  w_colour_cmd;
    logic                  w_fill_mode;
    logic                  w_bus_gnt;
    logic                  w_fill_gnt;
    logic                  w_fill_last;
    logic                  w_vs_fall;
    logic                  w_fill_pixel;

    assign w_op         = cmd_op_e'(CMD_OP);
    assign w_cmd_accept = CMD_VALID && (r_state == ST_IDLE);
    assign w_fill_cmd   = w_cmd_accept && ((w_op == OP_FILL_SOLID) || (w_op == OP_FILL_CHECK));
    assign w_colour_cmd = w_cmd_accept && (w_op == OP_SET_COLOURS);
    assign w_fill_mode  = (r_state == ST_FILL);
    assign w_fill_last  = (r_fill_addr == FILL_LAST);
    assign w_vs_fall    = r_vs_d && !VGA_VS;
    assign w_fill_pixel = r_pattern_check ? checker_pixel(r_fill_addr[8], r_fill_addr[0])
                                          : r_solid_val;

    // The fill engine requests the port on every cycle it is filling.
    fb_write_arbiter u_arbiter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_fill_mode(w_fill_mode),
        .i_bus_req  (BUS_VALID),
        .i_fill_req (w_fill_mode),
        .o_bus_gnt  (w_bus_gnt),
        .o_fill_gnt (w_fill_gnt)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: commands only start work from IDLE; op 11 is swallowed.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fill_cmd) begin
                    w_next_state = ST_FILL;
                end else if (w_colour_cmd) begin
                    w_next_state = ST_WAIT_VS;
                end
            end
            ST_FILL: begin
                if (w_fill_gnt && w_fill_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT_VS: begin
                if (w_vs_fall) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Fill engine: latch the pattern on command accept, step only when granted.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fill_addr     <= '0;
            r_pattern_check <= 1'b0;
            r_solid_val     <= 1'b0;
        end else if (w_fill_cmd) begin
            r_fill_addr     <= '0;
            r_pattern_check <= (w_op == OP_FILL_CHECK);
            r_solid_val     <= CMD_DATA[0];
        end else if (w_fill_gnt) begin
            r_fill_addr     <= r_fill_addr + ADDR_WIDTH'(1);
        end
    end

    // Colour register: a new word is held pending and applied on a vsync fall.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vs_d           <= 1'b1;
            r_pending_colour <= '0;
            r_colours        <= COLOUR_RESET;
        end else begin
            r_vs_d <= VGA_VS;
            if (w_colour_cmd) begin
                r_pending_colour <= CMD_DATA;
            end
            if ((r_state == ST_WAIT_VS) && w_vs_fall) begin
                r_colours <= r_pending_colour;
            end
        end
    end

    // Registered write port: one pulse per granted request, address/data held otherwise.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= 1'b0;
        end else begin
            r_fb_we <= w_bus_gnt || w_fill_gnt;
            if (w_bus_gnt) begin
                r_fb_addr <= BUS_ADDR;
                r_fb_data <= BUS_DATA;
            end else if (w_fill_gnt) begin
                r_fb_addr <= r_fill_addr;
                r_fb_data <= w_fill_pixel;
            end
        end
    end

    assign BUS_READY      = w_bus_gnt;
    assign CMD_READY      = (r_state == ST_IDLE);
    assign BUSY           = (r_state != ST_IDLE);
    assign FB_WE          = r_fb_we;
    assign FB_ADDR        = r_fb_addr;
    assign FB_DATA        = r_fb_data;
    assign CONFIG_COLOURS = r_colours;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Testbench for frame_buffer_ctrl. Uses a reduced address width so that the
// full-screen fills stay short; all counts scale with DEPTH.
module tb_frame_buffer_ctrl;

    localparam int AW    = 13;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bus_valid;
    logic [AW-1:0] bus_addr;
    logic          bus_data;
    logic          bus_ready;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [15:0]   cmd_data;
    logic          cmd_ready;
    logic          vga_vs;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic          fb_data;
    logic [15:0]   colours;
    logic          busy;

    int checks = 0;
    int errors = 0;

    frame_buffer_ctrl #(
        .ADDR_WIDTH  (AW),
        .COLOUR_RESET(16'h00FF)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .BUS_VALID     (bus_valid),
        .BUS_ADDR      (bus_addr),
        .BUS_DATA      (bus_data),
        .BUS_READY     (bus_ready),
        .CMD_VALID     (cmd_valid),
        .CMD_OP        (cmd_op),
        .CMD_DATA      (cmd_data),
        .CMD_READY     (cmd_ready),
        .VGA_VS        (vga_vs),
        .FB_WE         (fb_we),
        .FB_ADDR       (fb_addr),
        .FB_DATA       (fb_data),
        .CONFIG_COLOURS(colours),
        .BUSY          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0;
    localparam int M_FILL = 1;
    localparam int M_WAIT = 2;

    int          m_mode     = M_IDLE;
    int          m_next     = 0;
    bit          m_bus_last = 1'b1;   // bus won the last contest
    bit          m_check    = 1'b0;
    bit          m_solid    = 1'b0;
    logic [15:0] m_pending  = 16'h0;
    logic [15:0] m_colour   = 16'h00FF;
    bit          m_vs_prev  = 1'b1;
    bit          e_we       = 1'b0;
    int          e_addr     = 0;
    bit          e_data     = 1'b0;
    bit          model_live = 1'b0;

    function automatic bit bus_wins();
        if (m_mode != M_FILL) return 1'b1;
        return !m_bus_last;
    endfunction

    always @(posedge clk) begin
        int mode_now;
        bit bw;
        bit fw;
        if (!rst_n) begin
            m_mode = M_IDLE; m_next = 0; m_bus_last = 1'b1;
            m_pending = 16'h0; m_colour = 16'h00FF; m_vs_prev = 1'b1;
            e_we = 1'b0; e_addr = 0; e_data = 1'b0;
        end else begin
            mode_now = m_mode;
            bw = bus_valid && bus_wins();
            fw = (mode_now == M_FILL) && !bw;
            if (mode_now == M_FILL && bus_valid) m_bus_last = bw;
            e_we = bw || fw;
            if (bw) begin
                e_addr = int'(bus_addr);
                e_data = bus_data;
            end else if (fw) begin
                e_addr = m_next;
                e_data = m_check ? bit'(((m_next >> 8) ^ m_next) & 1) : m_solid;
                m_next++;
                if (m_next == DEPTH) m_mode = M_IDLE;
            end
            if (mode_now == M_IDLE && cmd_valid) begin
                if (cmd_op == 2'd0 || cmd_op == 2'd1) begin
                    m_mode = M_FILL; m_next = 0;
                    m_check = (cmd_op == 2'd1); m_solid = cmd_data[0];
                end else if (cmd_op == 2'd2) begin
                    m_pending = cmd_data; m_mode = M_WAIT;
                end
            end
            if (mode_now == M_WAIT && m_vs_prev && !vga_vs) begin
                m_colour = m_pending;
                m_mode = M_IDLE;
            end
            m_vs_prev = vga_vs;
        end
        model_live = 1'b1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            check("m_fb_we", fb_we, e_we);
            if (e_we) begin
                check("m_fb_addr", fb_addr, e_addr);
                check("m_fb_data", fb_data, e_data);
            end
            check("m_busy", busy, m_mode != M_IDLE);
            check("m_cmd_ready", cmd_ready, m_mode == M_IDLE);
            check("m_bus_ready", bus_ready, bus_valid && bus_wins());
            check("m_colours", colours, m_colour);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n, busy_n, writes, fills, kind, prev_kind;
        bit done, saw100, saw101;

        rst_n = 1'b0; bus_valid = 1'b1; bus_addr = '1; bus_data = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 16'hFFFF; vga_vs = 1'b1;
        repeat (3) tick();
        check("rst_fb_we", fb_we, 0);
        check("rst_colours", colours, 16'h00FF);
        check("rst_busy", busy, 0);
        rst_n = 1'b1; cmd_valid = 1'b0; bus_valid = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);

        // Idle bus write
        bus_valid = 1'b1; bus_addr = 13'h1234; bus_data = 1'b1;
        #1;
        check("idle_bus_ready", bus_ready, 1);
        tick();
        check("idle_we", fb_we, 1);
        check("idle_addr", fb_addr, 13'h1234);
        check("idle_data", fb_data, 1);
        bus_valid = 1'b0;

        // Solid fill, no contention
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 16'h0001;
        tick();
        cmd_valid = 1'b0;
        n = 0; busy_n = 0; done = 1'b0;
        for (int c = 0; c < DEPTH + 10 && !done; c++) begin
            if (busy) busy_n++;
            if (fb_we) begin
                check("solid_addr", fb_addr, n);
                check("solid_data", fb_data, 1);
                n++;
            end
            if (!busy) done = 1'b1;
            else tick();
        end
        check("solid_finished", done, 1);
        check("solid_count", n, DEPTH);
        check("solid_busy_cycles", busy_n, DEPTH);

        // Checkerboard fill with the bus continuously requesting
        bus_valid = 1'b1; bus_addr = 13'h1FFF; bus_data = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 16'h0000;
        tick();
        cmd_valid = 1'b0;
        prev_kind = -1; writes = 0; fills = 0; busy_n = 0;
        done = 1'b0; saw100 = 1'b0; saw101 = 1'b0;
        for (int c = 0; c < 2 * DEPTH + 10 && !done; c++) begin
            if (busy) busy_n++;
            if (fb_we) begin
                kind = (fb_addr == 13'h1FFF && fb_data == 1'b1) ? 1 : 0;
                if (prev_kind >= 0) check("chk_alternate", kind != prev_kind, 1);
                prev_kind = kind;
                writes++;
                if (kind == 0) begin
                    fills++;
                    if (fb_addr == 13'h0100) begin check("chk_pix_0100", fb_data, 1); saw100 = 1'b1; end
                    if (fb_addr == 13'h0101) begin check("chk_pix_0101", fb_data, 0); saw101 = 1'b1; end
                end
            end
            if (!busy) done = 1'b1;
            else tick();
        end
        check("chk_finished", done, 1);
        check("chk_writes", writes, 2 * DEPTH);
        check("chk_fills", fills, DEPTH);
        check("chk_busy_cycles", busy_n, 2 * DEPTH - 1);
        check("chk_saw_0100", saw100, 1);
        check("chk_saw_0101", saw101, 1);
        bus_valid = 1'b0;

        // Colour update synchronised to a vsync fall
        vga_vs = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 16'hE01C;
        #1;
        check("col_cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 99; c++) begin
            tick();
            check("col_hold", colours, 16'h00FF);
            check("col_cmd_ready_low", cmd_ready, 0);
        end
        vga_vs = 1'b0;
        @(negedge clk);
        check("col_before_edge", colours, 16'h00FF);
        tick();
        check("col_after_edge", colours, 16'hE01C);
        check("col_cmd_ready_back", cmd_ready, 1);

        // vsync already low at accept: must wait for the next fall
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 16'h1234;
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        check("col_low_hold", colours, 16'hE01C);
        check("col_low_busy", busy, 1);
        vga_vs = 1'b1;
        repeat (3) tick();
        check("col_high_hold", colours, 16'hE01C);
        vga_vs = 1'b0;
        tick();
        check("col_second_update", colours, 16'h1234);
        check("col_second_idle", busy, 0);

        // Reserved opcode is accepted and ignored
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_data = 16'hBEEF;
        #1;
        check("rsv_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("rsv_busy", busy, 0);
        check("rsv_colours", colours, 16'h1234);
        check("rsv_fb_we", fb_we, 0);

        // Reset in the middle of a fill
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 16'h0000;
        tick();
        cmd_valid = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (fb_we && fb_addr == 13'd1000) done = 1'b1;
            else tick();
        end
        check("rmid_reached_1000", done, 1);
        rst_n = 1'b0;
        tick();
        check("rmid_fb_we", fb_we, 0);
        check("rmid_busy", busy, 0);
        check("rmid_cmd_ready", cmd_ready, 1);
        check("rmid_colours", colours, 16'h00FF);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rmid_quiet", fb_we, 0);
        end
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 16'h0001;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("restart_we", fb_we, 1);
        check("restart_addr", fb_addr, 0);
        check("restart_data", fb_data, 1);
        done = 1'b0;
        for (int c = 0; c < DEPTH + 10 && !done; c++) begin
            if (!busy) done = 1'b1;
            else tick();
        end
        check("restart_finished", done, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
